array_reducer: RTL and testbench

- Hardware equivalent of the array sum / OR-reduce routine, placed directly upstream of the word-addressed `mem` block and acting as its sole master.
- On `start`, walks 32-bit words from `BASE_ADDR` in steps of 4 until it reads a zero word. It accumulates the wrap-around sum and the bitwise OR of the words.
- Writes the sum to `RESULT_ADDR` and the OR to `RESULT_ADDR+4`, then pulses `done`.

---
 rtl/reducer_pkg.sv | 15 +
 rtl/reduce_acc.sv | 56 +++++
 rtl/array_reducer.sv | 154 +++++++++++++++
 tb/tb_array_reducer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reducer_pkg.sv
// Shared types and constants for the array reducer.
package reducer_pkg;

   localparam int WORD_W      = 32;
   localparam int WORD_STRIDE = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WSUM,
      S_WOR,
      S_DONE
   } state_e;

endpackage

// File: rtl/reduce_acc.sv
// Sum / OR / count accumulator register set for the array reducer.
module reduce_acc
   import reducer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load_en,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] sum,
   output logic [WORD_W-1:0] orred,
   output logic [7:0]        count,
   output logic [WORD_W-1:0] sum_nxt,
   output logic [7:0]        count_nxt
);

   logic [WORD_W-1:0] sum_q, sum_d;
   logic [WORD_W-1:0] orred_q, orred_d;
   logic [7:0]        count_q, count_d;

   // Next accumulator values: clear wins, otherwise fold in one word.
   always_comb begin
      sum_d   = sum_q;
      orred_d = orred_q;
      count_d = count_q;
      if (clear) begin
         sum_d   = '0;
         orred_d = '0;
         count_d = '0;
      end else if (load_en) begin
         sum_d   = sum_q + din;
         orred_d = orred_q | din;
         count_d = count_q + 8'd1;
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q   <= '0;
         orred_q <= '0;
         count_q <= '0;
      end else begin
         sum_q   <= sum_d;
         orred_q <= orred_d;
         count_q <= count_d;
      end
   end

   assign sum       = sum_q;
   assign orred     = orred_q;
   assign count     = count_q;
   assign sum_nxt   = sum_d;
   assign count_nxt = count_d;

endmodule

// File: rtl/array_reducer.sv
// Walks a zero-terminated word array in mem, writes its sum and OR back.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | address = pointer, one word folded in per cycle
// WSUM   | writing sum to RESULT_ADDR
// WOR    | writing OR to RESULT_ADDR+4
// DONE   | one-cycle done pulse
//
// All memory-port outputs are registered, so each state's port values are
// loaded on the edge that enters that state.
module array_reducer
   import reducer_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0,
   parameter logic [WORD_W-1:0] RESULT_ADDR = 32'h20,
   parameter int                MAX_WORDS   = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [WORD_W-1:0] address,
   output logic [WORD_W-1:0] memIn,
   input  logic [WORD_W-1:0] memOut,
   output logic              read,
   output logic              write,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [WORD_W-1:0] sum,
   output logic [WORD_W-1:0] orred,
   output logic [7:0]        count
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] address_q, address_d;
   logic [WORD_W-1:0] mem_in_q, mem_in_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic              acc_clear;
   logic              acc_load;
   logic [WORD_W-1:0] sum_nxt;
   logic [7:0]        count_nxt;

   assign acc_clear = (state_q == S_IDLE) && start;
   assign acc_load  = (state_q == S_READ) && (memOut != '0);

   reduce_acc u_acc (
      .clk       (clk),
      .reset     (reset),
      .clear     (acc_clear),
      .load_en   (acc_load),
      .din       (memOut),
      .sum       (sum),
      .orred     (orred),
      .count     (count),
      .sum_nxt   (sum_nxt),
      .count_nxt (count_nxt)
   );

   // Next state and next registered port values.
   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      mem_in_d  = mem_in_q;
      read_d    = read_q;
      write_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            read_d = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               state_d   = S_READ;
               address_d = BASE_ADDR;
               read_d    = 1'b1;
               busy_d    = 1'b1;
               ovf_d     = 1'b0;
            end
         end
         S_READ: begin
            if (memOut == '0 || count_nxt == 8'(MAX_WORDS)) begin
               // sum_nxt already includes the word that hit the limit
               ovf_d     = (memOut != '0);
               state_d   = S_WSUM;
               address_d = RESULT_ADDR;
               mem_in_d  = sum_nxt;
               read_d    = 1'b0;
               write_d   = 1'b1;
            end else begin
               address_d = address_q + WORD_W'(WORD_STRIDE);
            end
         end
         S_WSUM: begin
            state_d   = S_WOR;
            address_d = RESULT_ADDR + WORD_W'(WORD_STRIDE);
            mem_in_d  = orred;
            write_d   = 1'b1;
         end
         S_WOR: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            read_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM and registered memory-port outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         address_q <= '0;
         mem_in_q  <= '0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         mem_in_q  <= mem_in_d;
         read_q    <= read_d;
         write_q   <= write_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign address = address_q;
   assign memIn   = mem_in_q;
   assign read    = read_q;
   assign write   = write_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_array_reducer.sv
// Bench for array_reducer: word memory model, write scoreboard, vector table.
module tb_array_reducer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] address;
   logic [31:0] memIn;
   logic [31:0] memOut;
   logic        read;
   logic        write;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [31:0] sum;
   logic [31:0] orred;
   logic [7:0]  count;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [16];
   int          reads_cnt = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t wq [$];

   typedef struct {
      logic [31:0] words [9];
      int          nw;
      logic [31:0] e_sum;
      logic [31:0] e_or;
      logic [7:0]  e_cnt;
      logic        e_ovf;
      string       name;
   } vec_t;
   vec_t vecs [5];

   array_reducer #(
      .BASE_ADDR   (32'h0),
      .RESULT_ADDR (32'h20),
      .MAX_WORDS   (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .address (address),
      .memIn   (memIn),
      .memOut  (memOut),
      .read    (read),
      .write   (write),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .sum     (sum),
      .orred   (orred),
      .count   (count)
   );

   always #5 clk = ~clk;

   assign memOut = read ? mem[address[5:2]] : 32'h0;

   // Memory model plus write scoreboard and read counter.
   always @(posedge clk) begin
      wr_t exp_w;
      if (read && write) begin
         checks++;
         errors++;
         $display("FAIL rw_overlap: read=%b write=%b required not both high", read, write);
      end
      if (write) begin
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h required no write", address, memIn);
         end else begin
            exp_w = wq.pop_front();
            if (address !== exp_w.a || memIn !== exp_w.d) begin
               errors++;
               $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                        address, memIn, exp_w.a, exp_w.d);
            end
         end
         mem[address[5:2]] <= memIn;
      end
      if (read) reads_cnt <= reads_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic preload(input vec_t v);
      for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
      for (int i = 0; i < v.nw; i++) mem[i] = v.words[i];
   endtask

   task automatic run_vec(input vec_t v, input bit poke);
      int lat;
      int rbase;
      logic [31:0] e_or;
      preload(v);
      wq.push_back('{a: 32'h20, d: v.e_sum});
      wq.push_back('{a: 32'h24, d: v.e_or});
      @(negedge clk);
      rbase = reads_cnt;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         start = poke && (lat == 1);
      end while (!done && lat < 40);
      start = 1'b0;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: done not seen after %0d edges", v.name, lat);
      end
      chk({v.name, " done_latency"}, lat, v.nw + 2);
      chk({v.name, " reads"}, reads_cnt - rbase, v.nw);
      @(posedge clk);
      #1;
      chk({v.name, " done_pulse"}, {31'b0, done}, 32'h0);
      chk({v.name, " busy_after"}, {31'b0, busy}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk({v.name, " sum"}, sum, v.e_sum);
      chk({v.name, " orred"}, orred, v.e_or);
      chk({v.name, " count"}, {24'b0, count}, {24'b0, v.e_cnt});
      chk({v.name, " ovf"}, {31'b0, ovf}, {31'b0, v.e_ovf});
      chk({v.name, " mem20"}, mem[8], v.e_sum);
      chk({v.name, " mem24"}, mem[9], v.e_or);
      chk({v.name, " pending_writes"}, wq.size(), 0);
      e_or = v.e_or;
   endtask

   initial begin
      vecs[0] = '{words: '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd11, 32'd0, 32'd0, 32'd0},
                  nw: 7, e_sum: 32'h24, e_or: 32'hF, e_cnt: 8'd6, e_ovf: 1'b0, name: "nominal"};
      vecs[1] = '{words: '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  nw: 1, e_sum: 32'h0, e_or: 32'h0, e_cnt: 8'd0, e_ovf: 1'b0, name: "empty"};
      vecs[2] = '{words: '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  nw: 3, e_sum: 32'h1, e_or: 32'hFFFFFFFF, e_cnt: 8'd2, e_ovf: 1'b0, name: "wrap"};
      vecs[3] = '{words: '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0},
                  nw: 8, e_sum: 32'h24, e_or: 32'hF, e_cnt: 8'd8, e_ovf: 1'b1, name: "noterm"};
      vecs[4] = '{words: '{32'h80000000, 32'h80000000, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  nw: 4, e_sum: 32'h7, e_or: 32'h80000007, e_cnt: 8'd3, e_ovf: 1'b0, name: "msb"};

      for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
      start = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'b0, busy}, 32'h0);
      chk("rst read", {31'b0, read}, 32'h0);
      chk("rst write", {31'b0, write}, 32'h0);
      chk("rst address", address, 32'h0);
      chk("rst sum", sum, 32'h0);
      chk("rst count", {24'b0, count}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

      // start pulsed during READ must be ignored; rerun must match
      run_vec(vecs[0], 1'b1);
      run_vec(vecs[0], 1'b0);

      // reset during the third READ cycle: no result writes may follow
      preload(vecs[0]);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst in_read", {31'b0, read}, 32'h1);
      chk("midrst address", address, 32'h8);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst busy", {31'b0, busy}, 32'h0);
      chk("midrst read", {31'b0, read}, 32'h0);
      chk("midrst write", {31'b0, write}, 32'h0);
      chk("midrst address0", address, 32'h0);
      chk("midrst memIn", memIn, 32'h0);
      chk("midrst sum", sum, 32'h0);
      chk("midrst orred", orred, 32'h0);
      chk("midrst count", {24'b0, count}, 32'h0);
      chk("midrst ovf", {31'b0, ovf}, 32'h0);
      chk("midrst done", {31'b0, done}, 32'h0);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst mem20", mem[8], 32'hDEADBEEF);
      chk("midrst mem24", mem[9], 32'hDEADBEEF);
      chk("midrst idle", {31'b0, busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
